// File: rtl/tester_ctrl_if.sv
// Command/memory/transmitter bundle for tester_ctrl.
// master = environment side, slave = controller side.
interface tester_ctrl_if #(
    parameter int DATA_W = 6,
    parameter int KEY_N  = 1
);
    logic              uart_push;
    logic [7:0]        i_uart_data;
    logic [KEY_N-1:0]  key_push;
    logic              reset_push;
    logic [DATA_W-1:0] mem;
    logic              mem_wrt_rd;
    logic              tx_busy;
    logic              tx_done;
    logic              mem_wrt_en;
    logic [DATA_W-1:0] mem_out;
    logic              tx_start;
    logic              rst_fsm;
    logic              busy;
    logic              err;

    modport master (
        output uart_push, i_uart_data, key_push,
        output reset_push, mem, mem_wrt_rd,
        output tx_busy, tx_done,
        input  mem_wrt_en, mem_out, tx_start,
        input  rst_fsm, busy, err
    );

    modport slave (
        input  uart_push, i_uart_data, key_push,
        input  reset_push, mem, mem_wrt_rd,
        input  tx_busy, tx_done,
        output mem_wrt_en, mem_out, tx_start,
        output rst_fsm, busy, err
    );
endinterface

// File: rtl/tester_ctrl.sv
// Tester controller: UART/key events -> memory write -> transmit.
// Optional watchdog enabled by defining TESTER_CTRL_TIMEOUT_EN.
module tester_ctrl #(
    parameter int DATA_W      = 6,
    parameter int KEY_N       = 1,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic         in_clk,
    input  logic         in_rst,
    tester_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE, WRITE, SEND_REQ, SEND_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_out_q, mem_out_d;
    logic              wr_en_q, wr_en_d;
    logic              tx_start_q, tx_start_d;
    logic              rst_fsm_q, rst_fsm_d;
    logic              err_q, err_d;
    logic              busy_q;

    logic [1:0]        opcode;
    logic              key_hit;
    logic [DATA_W-1:0] key_mask;

    assign opcode = bus.i_uart_data[7:6];

    // Descending scan so the lowest set key index wins.
    always_comb begin
        key_hit  = 1'b0;
        key_mask = '0;
        for (int k = KEY_N - 1; k >= 0; k--) begin
            if (bus.key_push[k]) begin
                key_hit  = 1'b1;
                key_mask = '0;
                key_mask[DATA_W-1-k] = 1'b1;
            end
        end
    end

`ifdef TESTER_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo;

    assign tmo = (state_q != IDLE) &&
                 (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

    always_comb begin
        state_d    = state_q;
        mem_out_d  = mem_out_q;
        wr_en_d    = wr_en_q;
        tx_start_d = 1'b0;
        rst_fsm_d  = 1'b0;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (bus.reset_push ||
                    (bus.uart_push && opcode == 2'b11)) begin
                    rst_fsm_d = 1'b1;
                    err_d     = 1'b0;
                end else if (bus.uart_push &&
                             opcode == 2'b10) begin
                    mem_out_d = bus.i_uart_data[DATA_W-1:0];
                    wr_en_d   = 1'b1;
                    state_d   = WRITE;
                end else if (bus.uart_push &&
                             opcode == 2'b01) begin
                    state_d = SEND_REQ;
                end else if (key_hit) begin
                    mem_out_d = bus.mem ^ key_mask;
                    wr_en_d   = 1'b1;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (bus.mem_wrt_rd) begin
                    wr_en_d = 1'b0;
                    state_d = SEND_REQ;
                end
            end
            SEND_REQ: begin
                if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = SEND_WAIT;
                end
            end
            SEND_WAIT: begin
                if (bus.tx_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef TESTER_CTRL_TIMEOUT_EN
        if (tmo) begin
            err_d      = 1'b1;
            wr_en_d    = 1'b0;
            tx_start_d = 1'b0;
            state_d    = IDLE;
        end
`endif
        // A reset press outranks every in-flight transaction.
        if (state_q != IDLE && bus.reset_push) begin
            wr_en_d    = 1'b0;
            tx_start_d = 1'b0;
            rst_fsm_d  = 1'b1;
            state_d    = IDLE;
        end
    end

`ifdef TESTER_CTRL_TIMEOUT_EN
    always_comb begin
        if (state_d == IDLE || state_d != state_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q    <= IDLE;
            mem_out_q  <= '0;
            wr_en_q    <= 1'b0;
            tx_start_q <= 1'b0;
            rst_fsm_q  <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_out_q  <= mem_out_d;
            wr_en_q    <= wr_en_d;
            tx_start_q <= tx_start_d;
            rst_fsm_q  <= rst_fsm_d;
            err_q      <= err_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    assign bus.mem_wrt_en = wr_en_q;
    assign bus.mem_out    = mem_out_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.rst_fsm    = rst_fsm_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_tester_ctrl.sv
// Scoreboard bench for tester_ctrl (DATA_W=6, KEY_N=2).
// Watchdog section runs when TESTER_CTRL_TIMEOUT_EN is defined.
module tb_tester_ctrl;
    localparam int DW = 6;
    localparam int KN = 2;
    localparam int TO = 8;
    localparam int EV_WR  = 0;
    localparam int EV_TX  = 1;
    localparam int EV_RST = 2;

    typedef struct {
        int          kind;
        logic [DW-1:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tester_ctrl_if #(.DATA_W(DW), .KEY_N(KN)) bus();

    tester_ctrl #(
        .DATA_W(DW), .KEY_N(KN), .TIMEOUT_CYC(TO)
    ) dut (
        .in_clk(clk),
        .in_rst(rst_n),
        .bus(bus)
    );

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    logic prev_we = 1'b0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h",
                     tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input int k,
                             input logic [DW-1:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic got(input int k, input logic [DW-1:0] d);
        ev_t e;
        if (sb.size() == 0) begin
            chk("sb_unexpected", k, 99);
        end else begin
            e = sb.pop_front();
            chk("sb_kind", k, e.kind);
            if (k == EV_WR) chk("sb_wr_data", d, e.data);
        end
    endtask

    // Output events are observed mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_wrt_en && !prev_we)
                got(EV_WR, bus.mem_out);
            if (bus.tx_start) got(EV_TX, '0);
            if (bus.rst_fsm) got(EV_RST, '0);
        end
        prev_we = bus.mem_wrt_en;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 want 0");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic uart(input logic [7:0] b);
        bus.uart_push = 1'b1;
        bus.i_uart_data = b;
        tick();
        bus.uart_push = 1'b0;
    endtask

    task automatic key(input logic [KN-1:0] k);
        bus.key_push = k;
        tick();
        bus.key_push = '0;
    endtask

    task automatic serve(input bit do_wr,
                         input int nack,
                         input int nbusy);
        int n;
        bus.tx_busy = 1'b1;
        if (do_wr) begin
            repeat (nack) begin
                chk("wr_hold", bus.mem_wrt_en, 1);
                tick();
            end
            bus.mem_wrt_rd = 1'b1;
            tick();
            bus.mem_wrt_rd = 1'b0;
            chk("wr_drop", bus.mem_wrt_en, 0);
            bus.mem = bus.mem_out;
        end
        repeat (nbusy) begin
            chk("tx_wait", bus.tx_start, 0);
            tick();
        end
        bus.tx_busy = 1'b0;
        n = 0;
        while (!bus.tx_start && n < 10) begin
            tick();
            n++;
        end
        chk("tx_seen", bus.tx_start, 1);
        tick();
        chk("tx_pulse", bus.tx_start, 0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("idle_after_tx", bus.busy, 0);
    endtask

    initial begin
        bus.uart_push   = 1'b0;
        bus.i_uart_data = '0;
        bus.key_push    = '0;
        bus.reset_push  = 1'b0;
        bus.mem         = '0;
        bus.mem_wrt_rd  = 1'b0;
        bus.tx_busy     = 1'b0;
        bus.tx_done     = 1'b0;

        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_we", bus.mem_wrt_en, 0);
        chk("rst_txs", bus.tx_start, 0);
        chk("rst_rfsm", bus.rst_fsm, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_mout", bus.mem_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // opcode 10: write then send
        expect_ev(EV_WR, 6'h15);
        expect_ev(EV_TX, '0);
        uart(8'h95);
        chk("u95_mout", bus.mem_out, 6'h15);
        chk("u95_busy", bus.busy, 1);
        serve(1, 2, 2);

        // opcode 00 is ignored
        uart(8'h3F);
        chk("op00_busy", bus.busy, 0);
        chk("op00_mout", bus.mem_out, 6'h15);

        // key 1 toggles bit 4
        bus.mem = 6'b100000;
        expect_ev(EV_WR, 6'b110000);
        expect_ev(EV_TX, '0);
        key(2'b10);
        chk("key1_mout", bus.mem_out, 6'b110000);
        serve(1, 3, 1);

        // both keys: index 0 wins; key during WRITE dropped
        expect_ev(EV_WR, 6'b010000);
        expect_ev(EV_TX, '0);
        key(2'b11);
        chk("key0_mout", bus.mem_out, 6'b010000);
        key(2'b01);
        chk("key_drop", bus.mem_out, 6'b010000);
        serve(1, 1, 0);

        // reset button beats simultaneous uart write
        expect_ev(EV_RST, '0);
        bus.reset_push = 1'b1;
        bus.uart_push = 1'b1;
        bus.i_uart_data = 8'h95;
        tick();
        bus.reset_push = 1'b0;
        bus.uart_push = 1'b0;
        chk("rp_rfsm", bus.rst_fsm, 1);
        chk("rp_busy", bus.busy, 0);
        chk("rp_we", bus.mem_wrt_en, 0);
        chk("rp_mout", bus.mem_out, 6'b010000);
        tick();
        chk("rp_once", bus.rst_fsm, 0);

        // send only; uart write in SEND_WAIT dropped
        expect_ev(EV_TX, '0);
        uart(8'h40);
        chk("send_we", bus.mem_wrt_en, 0);
        chk("send_busy", bus.busy, 1);
        tick();
        chk("send_txs", bus.tx_start, 1);
        uart(8'h95);
        chk("sw_we", bus.mem_wrt_en, 0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("sw_busy", bus.busy, 0);
        chk("sw_mout", bus.mem_out, 6'b010000);

        // abort mid-WRITE
        expect_ev(EV_WR, 6'h2A);
        expect_ev(EV_RST, '0);
        uart(8'hAA);
        tick();
        bus.reset_push = 1'b1;
        tick();
        bus.reset_push = 1'b0;
        chk("ab_we", bus.mem_wrt_en, 0);
        chk("ab_busy", bus.busy, 0);
        chk("ab_rfsm", bus.rst_fsm, 1);
        tick();

`ifdef TESTER_CTRL_TIMEOUT_EN
        expect_ev(EV_WR, 6'h15);
        expect_ev(EV_RST, '0);
        uart(8'h95);
        repeat (TO) begin
            chk("to_busy", bus.busy, 1);
            chk("to_err0", bus.err, 0);
            tick();
        end
        chk("to_err", bus.err, 1);
        chk("to_idle", bus.busy, 0);
        chk("to_we", bus.mem_wrt_en, 0);
        uart(8'hC0);
        chk("c0_err", bus.err, 0);
        chk("c0_rfsm", bus.rst_fsm, 1);
        tick();
        chk("c0_once", bus.rst_fsm, 0);
`else
        chk("err_tied", bus.err, 0);
`endif

        // asynchronous reset mid-WRITE
        expect_ev(EV_WR, 6'h15);
        uart(8'h95);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_we", bus.mem_wrt_en, 0);
        chk("ar_busy", bus.busy, 0);
        chk("ar_mout", bus.mem_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.uart_push = 1'b1;
        bus.i_uart_data = 8'h40;
        expect_ev(EV_TX, '0);
        tick();
        bus.uart_push = 1'b0;
        chk("first_edge", bus.busy, 1);
        serve(0, 0, 0);

        tick();
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tester_ctrl.md
TESTER_CTRL -- requirements
Module: tester_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 6: state-word width, legal range 1..6.
REQ-002 SHALL have parameter KEY_N, default 1: number of on/off keys, legal range 1..DATA_W.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1000: watchdog limit in clock cycles, minimum 2.
REQ-004 SHALL have port in_clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port in_rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port uart_push, input, 1: one-cycle strobe, i_uart_data valid.
REQ-007 SHALL have port i_uart_data, input, 8: command byte; [7:6] opcode, [5:0] payload.
REQ-008 SHALL have port key_push, input, KEY_N: one-cycle strobe per key; key k toggles state bit DATA_W-1-k.
REQ-009 SHALL have port reset_push, input, 1: one-cycle strobe from the reset button.
REQ-010 SHALL have port mem, input, DATA_W: current stored state word.
REQ-011 SHALL have port mem_wrt_rd, input, 1: memory write acknowledge.
REQ-012 SHALL have port tx_busy, input, 1: transmitter not ready.
REQ-013 SHALL have port tx_done, input, 1: transmission finished strobe.
REQ-014 SHALL have port mem_wrt_en, output, 1: memory write request.
REQ-015 SHALL have port mem_out, output, DATA_W: word to be written.
REQ-016 SHALL have port tx_start, output, 1: one-cycle transmit request.
REQ-017 SHALL have port rst_fsm, output, 1: one-cycle system reset pulse.
REQ-018 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-019 SHALL have port err, output, 1: sticky timeout flag.

Function
REQ-020 SHALL implement states IDLE, WRITE, SEND_REQ, SEND_WAIT; all outputs registered.
REQ-021 In IDLE, SHALL accept at most one event per cycle, priority: reset_push > uart opcode 11 > uart opcode 10/01 > key_push at lowest set index.
REQ-022 Reset event (reset_push or opcode 11): rst_fsm=1 for exactly one cycle starting next cycle, clear err, stay IDLE.
REQ-023 Opcode 10: mem_out <= i_uart_data[DATA_W-1:0], go WRITE; opcode 01: go SEND_REQ; opcode 00: ignored, no state change.
REQ-024 Key k: mem_out <= mem with bit DATA_W-1-k inverted, other bits unchanged, go WRITE.
REQ-025 Non-reset events arriving outside IDLE SHALL be dropped without effect.
REQ-026 reset_push in any non-IDLE state SHALL abort: drop mem_wrt_en and tx_start, pulse rst_fsm, go IDLE next cycle.
REQ-027 WRITE: mem_wrt_en=1 from the cycle after entry until the cycle mem_wrt_rd is sampled high; then mem_wrt_en=0, go SEND_REQ.
REQ-028 SEND_REQ: on first cycle with tx_busy=0, tx_start=1 for exactly one cycle, go SEND_WAIT.
REQ-029 SEND_WAIT: tx_done sampled high -> IDLE; tx_done outside SEND_WAIT is ignored.
REQ-030 mem_out SHALL hold its value until the next accepted write event.

Reset
REQ-031 in_rst low SHALL immediately force IDLE, mem_wrt_en=0, tx_start=0, rst_fsm=0, busy=0, err=0, mem_out=0, watchdog counter=0.
REQ-032 First event acceptance SHALL occur on the first rising edge after in_rst deasserts.

Configuration
REQ-033 With TESTER_CTRL_TIMEOUT_EN defined: a counter of width clog2(TIMEOUT_CYC+1) counts cycles in WRITE/SEND_REQ/SEND_WAIT, restarts on state change; on reaching TIMEOUT_CYC -> err=1, mem_wrt_en=0, IDLE next cycle.
REQ-034 Without TESTER_CTRL_TIMEOUT_EN: no counter; states wait indefinitely; err tied 0.

Verification
REQ-035 DATA_W=6, KEY_N=2, mem=6'b100000, key_push=2'b10 -> mem_out=6'b110000, mem_wrt_en high until mem_wrt_rd, then one tx_start pulse once tx_busy=0.
REQ-036 uart_push with i_uart_data=8'h95 -> mem_out=6'h15, write then send; uart byte 8'h40 -> send only, mem_wrt_en stays 0.
REQ-037 reset_push and uart 8'h95 in the same cycle -> single rst_fsm pulse, mem_out unchanged, no write.
REQ-038 uart 8'h95 pushed during SEND_WAIT -> dropped; after tx_done, busy=0 and mem_out unchanged.
REQ-039 TIMEOUT_EN, TIMEOUT_CYC=8, mem_wrt_rd never asserted -> err=1 and IDLE after 8 WRITE cycles; then uart 8'hC0 -> err=0, one rst_fsm pulse.
REQ-040 in_rst low mid-WRITE (asynchronous to the clock edge) -> mem_wrt_en=0, busy=0 immediately.
